// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory handshake, execute redirect and the decode-side outputs.
// The master modport is the fetch stage; the slave modport is its environment.
interface fetch_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 imem_req;
  logic [DataWidth-1:0] imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [DataWidth-1:0] imem_rdata;
  logic                 redirect;
  logic [DataWidth-1:0] redirect_target;
  logic                 stall;
  logic                 valid;
  logic [DataWidth-1:0] instruction;
  logic [DataWidth-1:0] pc_address;

  modport master (
    output imem_req, imem_addr, valid, instruction, pc_address,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_target, stall
  );

  modport slave (
    input  imem_req, imem_addr, valid, instruction, pc_address,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_target, stall
  );
endinterface

// File: rtl/fetch.sv
// RV32I instruction fetch: PC, request/grant/response to imem, small in-order queue to decode.
// Redirects flush the queue and discard responses still in flight.
module fetch #(
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] ResetVector = '0,
  parameter int unsigned          BufDepth    = 2
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);
  localparam int unsigned          PtrW  = $clog2(BufDepth);
  localparam int unsigned          CntW  = $clog2(BufDepth) + 1;
  localparam logic [CntW-1:0]      Depth = CntW'(BufDepth);
  localparam logic [DataWidth-1:0] Nop   = DataWidth'(32'h0000_0013);

  logic [DataWidth-1:0] fetch_pc_q;
  logic [DataWidth-1:0] pc_q   [BufDepth];
  logic [DataWidth-1:0] word_q [BufDepth];
  logic [BufDepth-1:0]  filled_q;
  logic [PtrW-1:0]      head_q, tail_q, fill_q;
  // outstanding_q counts only live requests; in-flight words to discard move into drop_q
  logic [CntW-1:0]      reserved_q, outstanding_q, drop_q;

  logic head_valid, deq, can_issue, req, issue, rsp_drop, rsp_fill;
  logic unused_target;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head_valid = rst & filled_q[head_q] & ~bus.redirect;
    deq        = head_valid & ~bus.stall;
    can_issue  = (reserved_q < Depth) | ((reserved_q == Depth) & deq);
    req        = rst & can_issue & ~bus.redirect & (drop_q == '0);
    issue      = req & bus.imem_gnt;
    rsp_drop   = bus.imem_rvalid & (drop_q != '0);
    rsp_fill   = bus.imem_rvalid & (drop_q == '0);
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.valid       = head_valid;
  assign bus.instruction = head_valid ? word_q[head_q] : Nop;
  assign bus.pc_address  = pc_q[head_q];
  assign unused_target   = ^bus.redirect_target[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= ResetVector;
      pc_q          <= '{default: ResetVector};
      filled_q      <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      fill_q        <= '0;
      reserved_q    <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else if (bus.redirect) begin
      fetch_pc_q    <= {bus.redirect_target[DataWidth-1:2], 2'b00};
      filled_q      <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      fill_q        <= '0;
      reserved_q    <= '0;
      outstanding_q <= '0;
      drop_q        <= drop_q + outstanding_q - CntW'(bus.imem_rvalid);
    end else begin
      // Head, new tail and fill slot are always distinct when they act in the same cycle.
      if (deq) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= ptr_inc(head_q);
      end
      if (issue) begin
        pc_q[tail_q]     <= fetch_pc_q;
        filled_q[tail_q] <= 1'b0;
        tail_q           <= ptr_inc(tail_q);
        fetch_pc_q       <= fetch_pc_q + DataWidth'(4);
      end
      if (rsp_fill) begin
        word_q[fill_q]   <= bus.imem_rdata;
        filled_q[fill_q] <= 1'b1;
        fill_q           <= ptr_inc(fill_q);
      end
      reserved_q    <= reserved_q + CntW'(issue) - CntW'(deq);
      outstanding_q <= outstanding_q + CntW'(issue) - CntW'(rsp_fill);
      drop_q        <= drop_q - CntW'(rsp_drop);
    end
  end

  no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
    !(bus.imem_rvalid && drop_q == '0 && outstanding_q == '0))
    else $error("imem response with no outstanding request");
endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: cycle table for free-run/stall, hand sequences for grant delay,
// redirect drops, back-to-back redirects, PC wrap and mid-stream reset.
module tb_fetch;
  localparam logic [31:0] Rv  = 32'h0000_0100;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if #(.DataWidth(32)) bus ();

  fetch #(
    .DataWidth  (32),
    .ResetVector(Rv),
    .BufDepth   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        stall;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  pend_t       pq[$];
  vec_t        vt[14];
  int          cyc, lat, n_tests, n_fail, s_cyc;
  logic        s_req, s_gnt, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_rsp();
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pq[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
  endtask

  // Called at a falling edge with inputs set; samples outputs, then advances one cycle.
  task automatic cycle();
    logic rsp;
    #1;
    s_req   = bus.imem_req;
    s_gnt   = bus.imem_gnt;
    s_addr  = bus.imem_addr;
    s_valid = bus.valid;
    s_pc    = bus.pc_address;
    s_instr = bus.instruction;
    s_cyc   = cyc;
    rsp     = bus.imem_rvalid;
    @(negedge clk);
    if (rsp) void'(pq.pop_front());
    if (s_req && s_gnt) pq.push_back('{addr: s_addr, due: cyc + lat});
    cyc++;
    drive_rsp();
  endtask

  task automatic do_reset();
    rst                 = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    bus.stall           = 1'b0;
    bus.imem_gnt        = 1'b1;
    bus.imem_rvalid     = 1'b0;
    bus.imem_rdata      = '0;
    pq.delete();
    #1;
    chk("rst.req_comb", bus.imem_req, 1'b0);
    @(negedge clk);
    #1;
    chk("rst.req", bus.imem_req, 1'b0);
    chk("rst.valid", bus.valid, 1'b0);
    chk("rst.addr", bus.imem_addr, Rv);
    chk("rst.instr", bus.instruction, Nop);
    chk("rst.pc", bus.pc_address, Rv);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    drive_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_req, first_valid;
    logic        seen;
    logic [31:0] exp_i, exp_v;
    logic [31:0] iss[$];
    logic [31:0] vpc[$];
    logic [31:0] vins[$];

    n_tests = 0;
    n_fail  = 0;

    // stall, exp_valid, exp_pc, exp_req, exp_addr
    vt[0]  = '{1'b0, 1'b0, 32'h100, 1'b1, 32'h100};
    vt[1]  = '{1'b0, 1'b0, 32'h100, 1'b1, 32'h104};
    vt[2]  = '{1'b0, 1'b1, 32'h100, 1'b1, 32'h108};
    vt[3]  = '{1'b0, 1'b1, 32'h104, 1'b1, 32'h10c};
    vt[4]  = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h110};
    vt[5]  = '{1'b1, 1'b1, 32'h10c, 1'b0, 32'h114};
    vt[6]  = '{1'b1, 1'b1, 32'h10c, 1'b0, 32'h114};
    vt[7]  = '{1'b1, 1'b1, 32'h10c, 1'b0, 32'h114};
    vt[8]  = '{1'b1, 1'b1, 32'h10c, 1'b0, 32'h114};
    vt[9]  = '{1'b1, 1'b1, 32'h10c, 1'b0, 32'h114};
    vt[10] = '{1'b0, 1'b1, 32'h10c, 1'b1, 32'h114};
    vt[11] = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h118};
    vt[12] = '{1'b0, 1'b1, 32'h114, 1'b1, 32'h11c};
    vt[13] = '{1'b0, 1'b1, 32'h118, 1'b1, 32'h120};

    // Free run with 1-cycle memory, including a 5-cycle stall.
    lat = 1;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      bus.stall = vt[i].stall;
      cycle();
      chk($sformatf("run[%0d].valid", i), s_valid, vt[i].exp_valid);
      chk($sformatf("run[%0d].pc", i), s_pc, vt[i].exp_pc);
      chk($sformatf("run[%0d].instr", i), s_instr,
          vt[i].exp_valid ? mem_word(vt[i].exp_pc) : Nop);
      chk($sformatf("run[%0d].req", i), s_req, vt[i].exp_req);
      if (vt[i].exp_req) chk($sformatf("run[%0d].addr", i), s_addr, vt[i].exp_addr);
    end
    bus.stall = 1'b0;

    // Mid-stream reset: reset values after one edge, then fetch restarts at the vector.
    do_reset();
    cycle();
    chk("rerst.req", s_req, 1'b1);
    chk("rerst.addr", s_addr, Rv);
    chk("rerst.valid", s_valid, 1'b0);

    // Grant withheld for 3 cycles.
    lat = 1;
    do_reset();
    bus.imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("gnt_wait[%0d].req", i), s_req, 1'b1);
      chk($sformatf("gnt_wait[%0d].addr", i), s_addr, Rv);
    end
    bus.imem_gnt = 1'b1;
    cycle();
    chk("gnt.req", s_req, 1'b1);
    chk("gnt.addr", s_addr, Rv);
    cycle();
    cycle();
    chk("gnt.valid", s_valid, 1'b1);
    chk("gnt.pc", s_pc, Rv);
    chk("gnt.instr", s_instr, mem_word(Rv));

    // Redirect with two requests outstanding, 3-cycle memory.
    lat = 3;
    do_reset();
    cycle();
    cycle();
    bus.redirect_target = 32'h203;
    bus.redirect        = 1'b1;
    cycle();
    chk("redir.req", s_req, 1'b0);
    chk("redir.valid", s_valid, 1'b0);
    bus.redirect = 1'b0;
    first_req   = -1;
    first_valid = -1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (s_req && s_gnt && first_req < 0) begin
        first_req = s_cyc;
        chk("redir.first_addr", s_addr, 32'h200);
      end
      if (s_valid && first_valid < 0) begin
        first_valid = s_cyc;
        chk("redir.first_pc", s_pc, 32'h200);
        chk("redir.first_instr", s_instr, mem_word(32'h200));
      end
    end
    chk("redir.first_req_cycle", first_req, 5);
    chk("redir.first_valid_cycle", first_valid, 9);

    // Back-to-back redirects: only the 0x800 stream may appear.
    lat = 3;
    do_reset();
    cycle();
    bus.redirect_target = 32'h400;
    bus.redirect        = 1'b1;
    cycle();
    chk("b2b.req0", s_req, 1'b0);
    bus.redirect_target = 32'h800;
    cycle();
    chk("b2b.req1", s_req, 1'b0);
    bus.redirect = 1'b0;
    exp_i = 32'h800;
    exp_v = 32'h800;
    seen  = 1'b0;
    for (int k = 0; k < 25; k++) begin
      cycle();
      if (s_req && s_gnt) begin
        chk("b2b.addr", s_addr, exp_i);
        exp_i += 32'd4;
      end
      if (s_valid) begin
        chk("b2b.pc", s_pc, exp_v);
        chk("b2b.instr", s_instr, mem_word(exp_v));
        seen = 1'b1;
        exp_v += 32'd4;
      end
    end
    chk("b2b.seen_valid", seen, 1'b1);

    // PC wrap; target low bits are forced to zero.
    lat = 1;
    do_reset();
    repeat (3) cycle();
    bus.redirect_target = 32'hFFFF_FFFE;
    bus.redirect        = 1'b1;
    cycle();
    chk("wrap.redir_req", s_req, 1'b0);
    bus.redirect = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (s_req && s_gnt) iss.push_back(s_addr);
      if (s_valid) begin
        vpc.push_back(s_pc);
        vins.push_back(s_instr);
      end
    end
    chk("wrap.n_issued", iss.size() >= 2, 1'b1);
    chk("wrap.n_valid", vpc.size() >= 2, 1'b1);
    if (iss.size() >= 2) begin
      chk("wrap.issue0", iss[0], 32'hFFFF_FFFC);
      chk("wrap.issue1", iss[1], 32'h0000_0000);
    end
    if (vpc.size() >= 2) begin
      chk("wrap.pc0", vpc[0], 32'hFFFF_FFFC);
      chk("wrap.pc1", vpc[1], 32'h0000_0000);
      chk("wrap.instr0", vins[0], mem_word(32'hFFFF_FFFC));
      chk("wrap.instr1", vins[1], mem_word(32'h0000_0000));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage of the RV32I pipeline. Holds the program counter, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned words in a small in-order queue. Presents `instruction`, `pc_address` and `valid` directly to the decode stage. Discards in-flight fetches when execute redirects the PC on a taken branch, JAL or JALR.

## Interface

Clocking and reset (already decided): one clock, `clk`; reset `rst` is synchronous and active-low, so the block resets on a rising `clk` edge with `rst`=0.

Parameters:
- `DataWidth`, 32: instruction and address width.
- `ResetVector`, 32'h0000_0000: first fetch address after reset.
- `BufDepth`, 2: fetch queue entries; legal values are 2 to 8.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  DataWidth  word-aligned fetch address.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; responses arrive in request order, at least 1 cycle after grant.
- `imem_rdata`  in  DataWidth  response instruction word.
- `redirect`  in  1  PC redirect from execute.
- `redirect_target`  in  DataWidth  new PC; bits [1:0] are ignored and forced to 0.
- `stall`  in  1  decode cannot accept this cycle.
- `valid`  out  1  `instruction`/`pc_address` are meaningful.
- `instruction`  out  DataWidth  fetched word.
- `pc_address`  out  DataWidth  address of `instruction`.

## Operation

State:
- `fetch_pc`: next address to request.
- Circular queue of `BufDepth` entries, each holding {pc, word, filled}.
- `reserved`: entries allocated, counting both filled and outstanding.
- `outstanding`: granted requests with no response yet.
- `drop`: responses still to be discarded.

Issue:
- `can_issue` = (`reserved` < BufDepth) or (`reserved` == BufDepth and the head is dequeued this cycle).
- `imem_req` = `can_issue` & ~`redirect` & (`drop` == 0).
- `imem_addr` = `fetch_pc`.
- On `imem_req`&`imem_gnt`: allocate the tail entry with pc=`fetch_pc`, filled=0; then `fetch_pc` += 4 and `outstanding`++.
- While `imem_req`=1 and `imem_gnt`=0, `imem_addr` holds stable unless a redirect occurs.

Response:
- If `drop` > 0: discard the word, `drop`--, `outstanding`--.
- Otherwise: write `imem_rdata` into the oldest unfilled entry, set filled=1, `outstanding`--.

Dequeue:
- `valid` = head filled & ~`redirect`.
- A dequeue occurs when `valid`=1 and `stall`=0. The head pointer advances and `reserved`--.
- `instruction`/`pc_address` come combinationally from the head entry. When `valid`=0, `instruction`=32'h0000_0013 (NOP) and `pc_address` holds the head pc.

Redirect (highest priority):
- Queue cleared: `reserved`=0, all filled flags cleared.
- `fetch_pc` <= {`redirect_target`[31:2], 2'b00}.
- `drop` <= `drop` + `outstanding` − (`imem_rvalid` ? 1 : 0).
- No request is issued in the redirect cycle.
- A second redirect while `drop` > 0 accumulates per the same formula; the last target wins.

Width rules: `fetch_pc` wraps modulo 2^32, so 32'hFFFF_FFFC + 4 = 0. Counters are $clog2(BufDepth)+1 bits wide and never exceed BufDepth.

## Timing

Reset values:
- `imem_req`=0, `imem_addr`=ResetVector, `valid`=0, `instruction`=32'h0000_0013, `pc_address`=ResetVector.
- `fetch_pc`=ResetVector; `reserved`=`outstanding`=`drop`=0.

Cycle numbering: cycle 0 is the first cycle with `rst`=1.
- Cycle 0: `imem_req`=1, `imem_addr`=ResetVector.
- With 1-cycle memory (grant at t, `imem_rvalid` at t+1), `valid`=1 at t+2.
- Throughput is 1 instruction per cycle with `BufDepth`≥2 and 1-cycle memory.
- Redirect at cycle t: `imem_req`=0 at t; first request to the target at t+1 if `drop`=0, otherwise the cycle after the last dropped response. First valid target instruction no earlier than t+3.

Boundary conditions:
- Queue full with no dequeue: `imem_req`=0.
- `stall` held: outputs stable and `valid` stays 1.
- Response while the queue is empty of unfilled entries and `drop`=0 is illegal; assert it in simulation.
- Reset mid-operation: all state returns to reset values in one cycle; pending memory responses are the memory's responsibility to squash.

## Test plan

- Reset then free-run, 1-cycle memory, ResetVector=0x100 -> `pc_address` 0x100, 0x104, 0x108 on consecutive cycles starting at cycle 2, each with `valid`=1.
- `stall`=1 for 5 cycles while fetching -> `valid`/`instruction`/`pc_address` frozen; `imem_req`=0 once 2 entries are reserved; no word lost or duplicated after release.
- `imem_gnt` withheld 3 cycles -> `imem_req`=1 and `imem_addr`=0x100 held stable; response word appears with `pc_address`=0x100.
- Redirect to 0x203 with 2 requests outstanding, 3-cycle memory -> both stale responses dropped; the next `valid` shows `pc_address`=0x200 and its memory word.
- Back-to-back redirects to 0x400 then 0x800 -> only the 0x800 stream is ever presented with `valid`=1.
- `fetch_pc`=0xFFFF_FFFC -> next request address is 0x0000_0000; assert `rst`=0 mid-stream -> next cycle `valid`=0 and `imem_addr`=ResetVector.
